// File: rtl/sha256_msg_feeder.sv
// Buffers a byte-length message into 512-bit blocks and streams each block to the SHA-256 core.
// Define SHA256_FEEDER_PINGPONG_EN for two banks so loading overlaps sending.
module sha256_msg_feeder (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [13:0] i_len_bytes,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  output logic        o_ready,
  input  logic        i_core_done,
  output logic        o_write,
  output logic [31:0] o_data,
  output logic [7:0]  o_N,
  output logic [8:0]  o_bit_miss,
  output logic        o_busy,
  output logic        o_msg_done,
  output logic        o_err
);

`ifdef SHA256_FEEDER_PINGPONG_EN
  localparam logic PINGPONG = 1'b1;
`else
  localparam logic PINGPONG = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_CORE, SEND, WAIT_BUSY} state_t;

  state_t      r_state;
  logic [31:0] r_buf [2][16];
  logic [1:0]  r_bankFull;
  logic [4:0]  r_bankNeed [2];
  logic        r_wrBank;
  logic        r_rdBank;
  logic [3:0]  r_wrIdx;
  logic [4:0]  r_sendIdx;
  logic [7:0]  r_blkLoaded;
  logic [7:0]  r_blkSent;
  logic [4:0]  r_lastNeed;
  logic [1:0]  r_lastBytes;

  logic        w_lenOk;
  logic [7:0]  w_N;
  logic [8:0]  w_bitMiss;
  logic [4:0]  w_lastNeed;
  logic        w_accept;
  logic        w_lastBlkLoad;
  logic [4:0]  w_needLoad;
  logic        w_lastWord;
  logic        w_finalAccept;
  logic        w_sendDone;
  logic        w_lastBlkSend;
  logic        w_curBufFull;
  logic [31:0] w_inWord;
  logic [3:0]  w_rdIdx;
  logic [31:0] w_sendWord;
  logic [1:0]  w_fullCnt;
  logic [2:0]  w_fullNext;
  logic [7:0]  w_loadedNext;
  logic        w_readyNext;

  // The missing-bit count is -(8*len) mod 512, so only the low length bits matter.
  assign w_lenOk    = (i_len_bytes != 14'd0) && (i_len_bytes <= 14'd16320);
  assign w_N        = i_len_bytes[13:6] + {7'd0, |i_len_bytes[5:0]};
  assign w_bitMiss  = 9'd0 - {i_len_bytes[5:0], 3'b000};
  assign w_lastNeed = (i_len_bytes[5:0] == 6'd0) ? 5'd16
                    : ({1'b0, i_len_bytes[5:2]} + {4'd0, |i_len_bytes[1:0]});

  assign w_accept      = i_valid && o_ready;
  assign w_lastBlkLoad = (r_blkLoaded == o_N - 8'd1);
  assign w_needLoad    = w_lastBlkLoad ? r_lastNeed : 5'd16;
  assign w_lastWord    = (({1'b0, r_wrIdx} + 5'd1) == w_needLoad);
  assign w_finalAccept = w_accept && w_lastWord;
  assign w_sendDone    = (r_state == SEND) && (r_sendIdx == 5'd16);
  assign w_lastBlkSend = (r_blkSent == o_N - 8'd1);
  assign w_curBufFull  = r_bankFull[r_rdBank] || (w_finalAccept && (r_wrBank == r_rdBank));

  always_comb begin
    w_inWord = i_data;
    if (w_lastBlkLoad && w_lastWord) begin
      case (r_lastBytes)
        2'd1:    w_inWord = {i_data[31:24], 24'd0};
        2'd2:    w_inWord = {i_data[31:16], 16'd0};
        2'd3:    w_inWord = {i_data[31:8], 8'd0};
        default: w_inWord = i_data;
      endcase
    end
  end

  assign w_rdIdx    = (r_state == SEND) ? r_sendIdx[3:0] : 4'd0;
  assign w_sendWord = ({1'b0, w_rdIdx} < r_bankNeed[r_rdBank]) ? r_buf[r_rdBank][w_rdIdx] : 32'd0;

  assign w_fullCnt    = {1'b0, r_bankFull[0]} + {1'b0, r_bankFull[1]};
  assign w_fullNext   = {1'b0, w_fullCnt} + {2'd0, w_finalAccept} - {2'd0, w_sendDone};
  assign w_loadedNext = r_blkLoaded + {7'd0, w_finalAccept};

  // Single bank refills only after WAIT_BUSY; two banks refill whenever one is free.
  always_comb begin
    w_readyNext = 1'b0;
    if (r_state == IDLE)
      w_readyNext = i_start && w_lenOk;
    else if (PINGPONG)
      w_readyNext = (w_fullNext < 3'd2) && (w_loadedNext < o_N);
    else
      w_readyNext = ((r_state == LOAD) && !w_finalAccept)
                 || ((r_state == WAIT_BUSY) && !i_core_done && !r_bankFull[r_rdBank]);
  end

  always_ff @(posedge i_clk) begin
    if (w_accept)
      r_buf[r_wrBank][r_wrIdx] <= w_inWord;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= IDLE;
      r_bankFull    <= 2'b00;
      r_bankNeed[0] <= 5'd0;
      r_bankNeed[1] <= 5'd0;
      r_wrBank      <= 1'b0;
      r_rdBank      <= 1'b0;
      r_wrIdx       <= 4'd0;
      r_sendIdx     <= 5'd0;
      r_blkLoaded   <= 8'd0;
      r_blkSent     <= 8'd0;
      r_lastNeed    <= 5'd0;
      r_lastBytes   <= 2'd0;
      o_ready       <= 1'b0;
      o_write       <= 1'b0;
      o_data        <= 32'd0;
      o_N           <= 8'd0;
      o_bit_miss    <= 9'd0;
      o_busy        <= 1'b0;
      o_msg_done    <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_err      <= 1'b0;
      o_msg_done <= 1'b0;
      o_ready    <= w_readyNext;

      if (w_accept)
        r_wrIdx <= w_lastWord ? 4'd0 : r_wrIdx + 4'd1;
      if (w_finalAccept) begin
        r_bankFull[r_wrBank] <= 1'b1;
        r_bankNeed[r_wrBank] <= w_needLoad;
        r_wrBank             <= r_wrBank ^ PINGPONG;
        r_blkLoaded          <= r_blkLoaded + 8'd1;
      end

      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (w_lenOk) begin
              o_N         <= w_N;
              o_bit_miss  <= w_bitMiss;
              r_lastNeed  <= w_lastNeed;
              r_lastBytes <= i_len_bytes[1:0];
              r_blkLoaded <= 8'd0;
              r_blkSent   <= 8'd0;
              r_wrIdx     <= 4'd0;
              r_bankFull  <= 2'b00;
              r_wrBank    <= 1'b0;
              r_rdBank    <= 1'b0;
              o_busy      <= 1'b1;
              r_state     <= LOAD;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_curBufFull)
            r_state <= WAIT_CORE;
        end
        WAIT_CORE: begin
          if (i_core_done) begin
            o_write   <= 1'b1;
            o_data    <= w_sendWord;
            r_sendIdx <= 5'd1;
            r_state   <= SEND;
          end
        end
        SEND: begin
          if (w_sendDone) begin
            o_write              <= 1'b0;
            o_data               <= 32'd0;
            r_sendIdx            <= 5'd0;
            r_bankFull[r_rdBank] <= 1'b0;
            r_rdBank             <= r_rdBank ^ PINGPONG;
            r_blkSent            <= r_blkSent + 8'd1;
            if (w_lastBlkSend) begin
              o_msg_done <= 1'b1;
              o_busy     <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_state <= WAIT_BUSY;
            end
          end else begin
            o_data    <= w_sendWord;
            r_sendIdx <= r_sendIdx + 5'd1;
          end
        end
        WAIT_BUSY: begin
          if (!i_core_done)
            r_state <= w_curBufFull ? WAIT_CORE : LOAD;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Scoreboard bench for sha256_msg_feeder: directed messages, expected core writes queued up front.
// Honours SHA256_FEEDER_PINGPONG_EN for the backpressure and refill expectations.
module tb_sha256_msg_feeder;

`ifdef SHA256_FEEDER_PINGPONG_EN
  localparam int   BP_ACCEPT = 32;
  localparam logic WB_READY  = 1'b1;
`else
  localparam int   BP_ACCEPT = 16;
  localparam logic WB_READY  = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [13:0] i_len_bytes;
  logic        i_valid;
  logic [31:0] i_data;
  logic        o_ready;
  logic        i_core_done;
  logic        o_write;
  logic [31:0] o_data;
  logic [7:0]  o_N;
  logic [8:0]  o_bit_miss;
  logic        o_busy;
  logic        o_msg_done;
  logic        o_err;

  int          total = 0;
  int          bad = 0;
  int          writesSeen = 0;
  int          doneSeen = 0;
  logic [31:0] expQ[$];
  logic [31:0] stim[$];
  logic [31:0] expWord;

  sha256_msg_feeder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_len_bytes(i_len_bytes),
    .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready), .i_core_done(i_core_done),
    .o_write(o_write), .o_data(o_data), .o_N(o_N), .o_bit_miss(o_bit_miss),
    .o_busy(o_busy), .o_msg_done(o_msg_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every core write pops one expected word.
  always @(negedge i_clk) begin
    if (o_msg_done === 1'b1) doneSeen++;
    if (o_write === 1'b1) begin
      writesSeen++;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got write data 0x%08h want no write", o_data);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("write_data", o_data, expWord);
      end
    end
  end

  task automatic applyStimulus(input logic [13:0] len);
    @(negedge i_clk);
    i_start = 1'b1;
    i_len_bytes = len;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic feedWords(input int count, input int budget, output int accepted);
    int cyc;
    accepted = 0;
    cyc = 0;
    while (accepted < count && cyc < budget) begin
      @(negedge i_clk);
      cyc++;
      i_valid = 1'b1;
      i_data = stim[0];
      if (o_ready) begin
        accepted++;
        void'(stim.pop_front());
      end
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    i_data = 32'd0;
  endtask

  task automatic waitMsgDone(input string name, input int budget);
    logic got;
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge i_clk);
      if (o_msg_done) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput(name, {31'd0, got}, 32'd1);
  endtask

  task automatic pushBlock(input logic [31:0] first);
    expQ.push_back(first);
    for (int k = 0; k < 15; k++) expQ.push_back(32'd0);
  endtask

  initial begin
    int acc;
    int base;
    int wBase;
    i_rst = 1'b0;
    i_start = 1'b0;
    i_len_bytes = 14'd0;
    i_valid = 1'b0;
    i_data = 32'd0;
    i_core_done = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("rst_ready", {31'd0, o_ready}, 32'd0);
    checkOutput("rst_write", {31'd0, o_write}, 32'd0);
    checkOutput("rst_N", {24'd0, o_N}, 32'd0);
    checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
    i_rst = 1'b1;

    // Short message "abc" with a junk trailing byte.
    i_core_done = 1'b1;
    pushBlock(32'h61626300);
    base = doneSeen;
    applyStimulus(14'd3);
    checkOutput("t1_N", {24'd0, o_N}, 32'd1);
    checkOutput("t1_bit_miss", {23'd0, o_bit_miss}, 32'd488);
    checkOutput("t1_err", {31'd0, o_err}, 32'd0);
    checkOutput("t1_busy", {31'd0, o_busy}, 32'd1);
    stim.push_back(32'h616263FF);
    feedWords(1, 50, acc);
    checkOutput("t1_accepted", acc, 32'd1);
    waitMsgDone("t1_msg_done", 100);
    repeat (2) @(negedge i_clk);
    checkOutput("t1_done_pulses", doneSeen - base, 32'd1);
    checkOutput("t1_queue_empty", expQ.size(), 32'd0);
    checkOutput("t1_busy_end", {31'd0, o_busy}, 32'd0);

    // Exactly one full block.
    for (int k = 0; k < 16; k++) begin
      stim.push_back(32'h00010203 + k * 32'h04040404);
      expQ.push_back(32'h00010203 + k * 32'h04040404);
    end
    applyStimulus(14'd64);
    checkOutput("t2_N", {24'd0, o_N}, 32'd1);
    checkOutput("t2_bit_miss", {23'd0, o_bit_miss}, 32'd0);
    feedWords(16, 100, acc);
    checkOutput("t2_accepted", acc, 32'd16);
    waitMsgDone("t2_msg_done", 100);
    checkOutput("t2_queue_empty", expQ.size(), 32'd0);

    // 65 bytes: second block holds one byte and must wait for a fresh done.
    wBase = writesSeen;
    for (int k = 0; k < 16; k++) begin
      stim.push_back(32'hA0000000 + k);
      expQ.push_back(32'hA0000000 + k);
    end
    applyStimulus(14'd65);
    checkOutput("t3_N", {24'd0, o_N}, 32'd2);
    checkOutput("t3_bit_miss", {23'd0, o_bit_miss}, 32'd504);
    feedWords(16, 100, acc);
    repeat (25) @(negedge i_clk);
    checkOutput("t3_block1_writes", writesSeen - wBase, 32'd16);
    checkOutput("t3_ready_wait_busy", {31'd0, o_ready}, {31'd0, WB_READY});
    applyStimulus(14'd0);
    checkOutput("t3_start_ignored_err", {31'd0, o_err}, 32'd0);
    checkOutput("t3_N_held", {24'd0, o_N}, 32'd2);
    i_core_done = 1'b0;
    repeat (2) @(negedge i_clk);
    checkOutput("t3_ready_refill", {31'd0, o_ready}, 32'd1);
    pushBlock(32'hAB000000);
    stim.push_back(32'hABCDEF12);
    feedWords(1, 50, acc);
    repeat (5) @(negedge i_clk);
    checkOutput("t3_no_write_until_done", writesSeen - wBase, 32'd16);
    i_core_done = 1'b1;
    waitMsgDone("t3_msg_done", 100);
    checkOutput("t3_queue_empty", expQ.size(), 32'd0);
    checkOutput("t3_total_writes", writesSeen - wBase, 32'd32);

    // Backpressure with the core never ready.
    i_core_done = 1'b0;
    wBase = writesSeen;
    for (int k = 0; k < 32; k++) stim.push_back(32'h5A5A0000 + k);
    applyStimulus(14'd128);
    checkOutput("t4_N", {24'd0, o_N}, 32'd2);
    feedWords(32, 60, acc);
    checkOutput("t4_accepted", acc, BP_ACCEPT);
    checkOutput("t4_ready_low", {31'd0, o_ready}, 32'd0);
    checkOutput("t4_no_writes", writesSeen - wBase, 32'd0);
    stim.delete();
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    checkOutput("t4_busy_after_reset", {31'd0, o_busy}, 32'd0);

    // Illegal lengths.
    applyStimulus(14'd0);
    checkOutput("t5_err_len0", {31'd0, o_err}, 32'd1);
    checkOutput("t5_busy_len0", {31'd0, o_busy}, 32'd0);
    @(negedge i_clk);
    checkOutput("t5_err_pulse_len0", {31'd0, o_err}, 32'd0);
    applyStimulus(14'd16321);
    checkOutput("t5_err_len16321", {31'd0, o_err}, 32'd1);
    checkOutput("t5_ready_len16321", {31'd0, o_ready}, 32'd0);
    @(negedge i_clk);
    checkOutput("t5_err_pulse_len16321", {31'd0, o_err}, 32'd0);

    // Reset during the 8th write of a block, then a clean message.
    i_core_done = 1'b1;
    pushBlock(32'h11223300);
    stim.push_back(32'h11223344);
    applyStimulus(14'd3);
    feedWords(1, 50, acc);
    acc = 0;
    for (int c = 0; c < 60 && acc < 8; c++) begin
      if (o_write) acc++;
      if (acc < 8) @(negedge i_clk);
    end
    checkOutput("t6_reached_8th_write", acc, 32'd8);
    #1;
    i_rst = 1'b0;
    expQ.delete();
    @(negedge i_clk);
    checkOutput("t6_rst_write", {31'd0, o_write}, 32'd0);
    checkOutput("t6_rst_data", o_data, 32'd0);
    checkOutput("t6_rst_N", {24'd0, o_N}, 32'd0);
    checkOutput("t6_rst_bit_miss", {23'd0, o_bit_miss}, 32'd0);
    checkOutput("t6_rst_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("t6_rst_ready", {31'd0, o_ready}, 32'd0);
    checkOutput("t6_rst_msg_done", {31'd0, o_msg_done}, 32'd0);
    i_rst = 1'b1;
    pushBlock(32'h61626300);
    stim.push_back(32'h616263FF);
    applyStimulus(14'd3);
    checkOutput("t6_N", {24'd0, o_N}, 32'd1);
    checkOutput("t6_bit_miss", {23'd0, o_bit_miss}, 32'd488);
    feedWords(1, 50, acc);
    waitMsgDone("t6_msg_done", 100);
    checkOutput("t6_queue_empty", expQ.size(), 32'd0);

    repeat (2) @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
